// File: rtl/fft_pkg.sv
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared constants and types for the 8-point FFT output
//             serializer (data widths, bin count, FSM encoding, magnitude
//             width).
//  Ports    : none (package)
//  Options  : FFT_OUT_MAG_SQ_EN enables the squared-magnitude output path
//             in the blocks that import this package.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int DATA_W = 16;
    localparam int N_PTS  = 8;
    localparam int IDX_W  = 3;
    localparam int MAG_W  = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage : fft_pkg

`default_nettype wire

// File: rtl/fft_out_serializer_if.sv
// ============================================================================
//  Module   : fft_out_serializer_if
//  Purpose  : Streaming output bus of the FFT serializer: one bin per beat
//             with valid/ready handshake, bin index and last-bin flag.
//  Ports    : out_valid, out_ready, out_re, out_im, out_idx, out_last,
//             out_mag (only when FFT_OUT_MAG_SQ_EN is defined).
//  Modports : master - serializer side, slave - sink side.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_out_serializer_if;
    import fft_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
`ifdef FFT_OUT_MAG_SQ_EN
    logic [MAG_W-1:0]  out_mag;
`endif

    modport master (
        output out_valid, out_re, out_im, out_idx, out_last,
`ifdef FFT_OUT_MAG_SQ_EN
        output out_mag,
`endif
        input  out_ready
    );

    modport slave (
        input  out_valid, out_re, out_im, out_idx, out_last,
`ifdef FFT_OUT_MAG_SQ_EN
        input  out_mag,
`endif
        output out_ready
    );

endinterface : fft_out_serializer_if

`default_nettype wire

// File: rtl/fft_mag_sq.sv
// ============================================================================
//  Module   : fft_mag_sq
//  Purpose  : Combinational squared magnitude re^2 + im^2 of one complex
//             two's-complement sample. The result never exceeds 2^31, so it
//             fits a 32-bit unsigned value without overflow.
//  Ports    : i_re, i_im (DATA_W signed in), o_mag (MAG_W unsigned out)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_mag_sq
    import fft_pkg::*;
(
    input  wire logic [DATA_W-1:0] i_re,
    input  wire logic [DATA_W-1:0] i_im,
    output logic      [MAG_W-1:0]  o_mag
);

    // Sign-extend to full product width so the multiply is exact signed.
    logic signed [2*DATA_W-1:0] w_re_ext;
    logic signed [2*DATA_W-1:0] w_im_ext;
    logic signed [2*DATA_W-1:0] w_re_sq;
    logic signed [2*DATA_W-1:0] w_im_sq;

    assign w_re_ext = {{DATA_W{i_re[DATA_W-1]}}, i_re};
    assign w_im_ext = {{DATA_W{i_im[DATA_W-1]}}, i_im};
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    // Each square is non-negative and at most 2^30, so the unsigned sum is exact.
    assign o_mag = MAG_W'($unsigned(w_re_sq)) + MAG_W'($unsigned(w_im_sq));

endmodule : fft_mag_sq

`default_nettype wire

// File: rtl/fft_out_serializer.sv
// ============================================================================
//  Module   : fft_out_serializer
//  Purpose  : Captures the eight complex FFT results in one cycle on a load
//             strobe and streams them out bin 0..7 over a valid/ready bus.
//             A load landing on the final handshake starts the next frame
//             with no bubble; any other load while sending is dropped and
//             flagged on overrun.
//  Ports    : clk, reset_n (async active-low), load, X_k_re/X_k_im (k=0..7),
//             out_if (master modport of fft_out_serializer_if), busy, overrun
//  Options  : FFT_OUT_MAG_SQ_EN adds out_mag = re^2 + im^2 per beat.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_out_serializer
    import fft_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              load,
    input  wire logic [DATA_W-1:0] X_0_re,
    input  wire logic [DATA_W-1:0] X_0_im,
    input  wire logic [DATA_W-1:0] X_1_re,
    input  wire logic [DATA_W-1:0] X_1_im,
    input  wire logic [DATA_W-1:0] X_2_re,
    input  wire logic [DATA_W-1:0] X_2_im,
    input  wire logic [DATA_W-1:0] X_3_re,
    input  wire logic [DATA_W-1:0] X_3_im,
    input  wire logic [DATA_W-1:0] X_4_re,
    input  wire logic [DATA_W-1:0] X_4_im,
    input  wire logic [DATA_W-1:0] X_5_re,
    input  wire logic [DATA_W-1:0] X_5_im,
    input  wire logic [DATA_W-1:0] X_6_re,
    input  wire logic [DATA_W-1:0] X_6_im,
    input  wire logic [DATA_W-1:0] X_7_re,
    input  wire logic [DATA_W-1:0] X_7_im,
    fft_out_serializer_if.master   out_if,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_PTS - 1);

    logic [DATA_W-1:0] w_in_re [N_PTS];
    logic [DATA_W-1:0] w_in_im [N_PTS];

    assign w_in_re[0] = X_0_re;  assign w_in_im[0] = X_0_im;
    assign w_in_re[1] = X_1_re;  assign w_in_im[1] = X_1_im;
    assign w_in_re[2] = X_2_re;  assign w_in_im[2] = X_2_im;
    assign w_in_re[3] = X_3_re;  assign w_in_im[3] = X_3_im;
    assign w_in_re[4] = X_4_re;  assign w_in_im[4] = X_4_im;
    assign w_in_re[5] = X_5_re;  assign w_in_im[5] = X_5_im;
    assign w_in_re[6] = X_6_re;  assign w_in_im[6] = X_6_im;
    assign w_in_re[7] = X_7_re;  assign w_in_im[7] = X_7_im;

    state_t            state_q,    state_d;
    logic [IDX_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [DATA_W-1:0] bank_re_q [N_PTS];
    logic [DATA_W-1:0] bank_re_d [N_PTS];
    logic [DATA_W-1:0] bank_im_q [N_PTS];
    logic [DATA_W-1:0] bank_im_d [N_PTS];
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_re_q,    out_re_d;
    logic [DATA_W-1:0] out_im_q,    out_im_d;
    logic [IDX_W-1:0]  out_idx_q,   out_idx_d;
    logic              out_last_q,  out_last_d;
    logic              overrun_q,   overrun_d;
    logic              w_hs;
    logic              w_final_hs;
    logic              w_capture;

`ifdef FFT_OUT_MAG_SQ_EN
    logic [MAG_W-1:0]  w_in_mag   [N_PTS];
    logic [MAG_W-1:0]  bank_mag_q [N_PTS];
    logic [MAG_W-1:0]  bank_mag_d [N_PTS];
    logic [MAG_W-1:0]  out_mag_q,  out_mag_d;

    // Magnitudes are formed from the live inputs so they are banked in the
    // same cycle as the re/im values they belong to.
    for (genvar k = 0; k < N_PTS; k++) begin : g_mag
        fft_mag_sq u_mag_sq (
            .i_re  (w_in_re[k]),
            .i_im  (w_in_im[k]),
            .o_mag (w_in_mag[k])
        );
    end
`endif

    assign w_hs       = out_valid_q & out_if.out_ready;
    assign w_final_hs = w_hs & (rd_ptr_q == c_LAST_IDX);

    // Next-state and next-output logic. Output registers are loaded from the
    // *next* bank/pointer so a beat is presented the cycle after it is chosen.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        bank_re_d = bank_re_q;
        bank_im_d = bank_im_q;
        overrun_d = 1'b0;
        w_capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    w_capture = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_final_hs) begin
                    if (load) begin
                        w_capture = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        rd_ptr_d = '0;
                    end
                end else if (w_hs) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                // Only the final handshake may accept a new frame.
                if (load && !w_final_hs) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rd_ptr_d = '0;
            end
        endcase

        if (w_capture) begin
            state_d  = ST_SEND;
            rd_ptr_d = '0;
            for (int k = 0; k < N_PTS; k++) begin
                bank_re_d[k] = w_in_re[k];
                bank_im_d[k] = w_in_im[k];
            end
        end

        out_valid_d = (state_d == ST_SEND);
        out_re_d    = out_valid_d ? bank_re_d[rd_ptr_d] : '0;
        out_im_d    = out_valid_d ? bank_im_d[rd_ptr_d] : '0;
        out_idx_d   = out_valid_d ? rd_ptr_d : '0;
        out_last_d  = out_valid_d && (rd_ptr_d == c_LAST_IDX);
    end

`ifdef FFT_OUT_MAG_SQ_EN
    always_comb begin
        bank_mag_d = bank_mag_q;
        if (w_capture) begin
            for (int k = 0; k < N_PTS; k++) begin
                bank_mag_d[k] = w_in_mag[k];
            end
        end
        out_mag_d = out_valid_d ? bank_mag_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_PTS; k++) begin
                bank_mag_q[k] <= '0;
            end
            out_mag_q <= '0;
        end else begin
            bank_mag_q <= bank_mag_d;
            out_mag_q  <= out_mag_d;
        end
    end

    assign out_if.out_mag = out_mag_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            for (int k = 0; k < N_PTS; k++) begin
                bank_re_q[k] <= '0;
                bank_im_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            bank_re_q   <= bank_re_d;
            bank_im_q   <= bank_im_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_re    = out_re_q;
    assign out_if.out_im    = out_im_q;
    assign out_if.out_idx   = out_idx_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = (state_q == ST_SEND);
    assign overrun          = overrun_q;

endmodule : fft_out_serializer

`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
// ============================================================================
//  Module   : tb_fft_out_serializer
//  Purpose  : Self-checking bench for fft_out_serializer. Frames come from a
//             vector table; expected beats are queued when a frame is loaded
//             and compared whenever the DUT presents a valid beat.
//  Options  : FFT_OUT_MAG_SQ_EN also checks out_mag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_out_serializer;
    import fft_pkg::*;

    localparam int c_NF = 8;

    typedef struct {
        logic [DATA_W-1:0] in_re;
        logic [DATA_W-1:0] in_im;
        logic [DATA_W-1:0] exp_re;
        logic [DATA_W-1:0] exp_im;
        logic [IDX_W-1:0]  exp_idx;
        logic              exp_last;
        logic [MAG_W-1:0]  exp_mag;
    } vec_t;

    logic              clk;
    logic              reset_n;
    logic              load;
    logic [DATA_W-1:0] x_re [N_PTS];
    logic [DATA_W-1:0] x_im [N_PTS];
    logic              busy;
    logic              overrun;

    fft_out_serializer_if out_if ();

    fft_out_serializer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .X_0_re  (x_re[0]), .X_0_im (x_im[0]),
        .X_1_re  (x_re[1]), .X_1_im (x_im[1]),
        .X_2_re  (x_re[2]), .X_2_im (x_im[2]),
        .X_3_re  (x_re[3]), .X_3_im (x_im[3]),
        .X_4_re  (x_re[4]), .X_4_im (x_im[4]),
        .X_5_re  (x_re[5]), .X_5_im (x_im[5]),
        .X_6_re  (x_re[6]), .X_6_im (x_im[6]),
        .X_7_re  (x_re[7]), .X_7_im (x_im[7]),
        .out_if  (out_if),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vec [c_NF*N_PTS];
    vec_t exp_q [$];
    int   checks;
    int   errors;
    int   beats;
    int   ovr_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Runs on every falling edge: any valid beat must match the head of the
    // queue (also while stalled); it is retired when out_ready is high.
    task automatic monitor_step();
        vec_t e;
        if (overrun) ovr_cnt++;
        if (reset_n && out_if.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(out_if.out_idx), 64'hFFFF);
            end else begin
                e = exp_q[0];
                check("beat_re",   64'(out_if.out_re),   64'(e.exp_re));
                check("beat_im",   64'(out_if.out_im),   64'(e.exp_im));
                check("beat_idx",  64'(out_if.out_idx),  64'(e.exp_idx));
                check("beat_last", 64'(out_if.out_last), 64'(e.exp_last));
`ifdef FFT_OUT_MAG_SQ_EN
                check("beat_mag",  64'(out_if.out_mag),  64'(e.exp_mag));
`endif
                if (out_if.out_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    endtask

    function automatic void fill_table();
        int re, im;
        longint r, i;
        for (int f = 0; f < c_NF; f++) begin
            for (int k = 0; k < N_PTS; k++) begin
                case (f)
                    0: begin re = k * 100;          im = -k;             end
                    1: begin re = 1000 + k;         im = 7 * k;          end
                    2: begin re = 16'hDEAD ^ k;     im = 16'hBEEF;       end
                    3: begin re = k + 50;           im = 5000 - k;       end
                    4: begin re = -1000 * k;        im = 3 * k + 1;      end
                    5: begin re = 16'h1111 * k;     im = 16'h0F0F;       end
                    6: begin re = 32767 - k;        im = -32768 + k;     end
                    default: begin
                        if (k == 0)      begin re = -32768; im = -32768; end
                        else if (k == 3) begin re = 3;      im = -4;     end
                        else             begin re = k;      im = k;      end
                    end
                endcase
                vec[f*N_PTS+k].in_re    = 16'(re);
                vec[f*N_PTS+k].in_im    = 16'(im);
                vec[f*N_PTS+k].exp_re   = 16'(re);
                vec[f*N_PTS+k].exp_im   = 16'(im);
                vec[f*N_PTS+k].exp_idx  = 3'(k);
                vec[f*N_PTS+k].exp_last = (k == N_PTS - 1);
                r = longint'($signed(16'(re)));
                i = longint'($signed(16'(im)));
                vec[f*N_PTS+k].exp_mag  = 32'(r * r + i * i);
            end
        end
    endfunction

    // Drives frame f on the inputs with load high, starting just after a rising edge.
    task automatic drive_load(input int f);
        @(posedge clk);
        #1;
        for (int k = 0; k < N_PTS; k++) begin
            x_re[k] = vec[f*N_PTS+k].in_re;
            x_im[k] = vec[f*N_PTS+k].in_im;
        end
        load = 1'b1;
    endtask

    task automatic push_frame(input int f, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(vec[f*N_PTS+k]);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        int b0, o0;
        bit pat [4];
        checks  = 0;
        errors  = 0;
        beats   = 0;
        ovr_cnt = 0;
        reset_n = 1'b0;
        load    = 1'b0;
        out_if.out_ready = 1'b1;
        for (int k = 0; k < N_PTS; k++) begin
            x_re[k] = '0;
            x_im[k] = '0;
        end
        fill_table();

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid",   64'(out_if.out_valid), 64'd0);
        check("rst_re",      64'(out_if.out_re),    64'd0);
        check("rst_im",      64'(out_if.out_im),    64'd0);
        check("rst_idx",     64'(out_if.out_idx),   64'd0);
        check("rst_last",    64'(out_if.out_last),  64'd0);
        check("rst_busy",    64'(busy),             64'd0);
        check("rst_overrun", 64'(overrun),          64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle with ready high: nothing streams
        repeat (6) @(negedge clk);
        check("idle_beats", 64'(beats), 64'd0);
        check("idle_busy",  64'(busy),  64'd0);

        // Frame 0 with ready held high: latency and 9-cycle frame
        b0 = beats;
        drive_load(0);
        push_frame(0, N_PTS);
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check("lat_valid", 64'(out_if.out_valid), 64'd1);
        check("lat_idx",   64'(out_if.out_idx),   64'd0);
        repeat (7) @(posedge clk);
        #1 check("busy_during", 64'(busy), 64'd1);
        @(posedge clk);
        #1 check("busy_after", 64'(busy), 64'd0);
        check("f0_empty", 64'(exp_q.size()), 64'd0);
        check("f0_beats", 64'(beats - b0), 64'd8);

        // Same frame with out_ready pattern 1,0,0,1
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        b0 = beats;
        drive_load(0);
        push_frame(0, N_PTS);
        for (int c = 0; c < 80 && (exp_q.size() != 0 || busy || c == 0); c++) begin
            @(posedge clk);
            #1;
            load = 1'b0;
            out_if.out_ready = pat[c % 4];
        end
        out_if.out_ready = 1'b1;
        wait_drain("stall_drain", 10);
        check("stall_beats", 64'(beats - b0), 64'd8);

        // Overrun: load of frame 2 during streaming of frame 1 is dropped
        o0 = ovr_cnt;
        drive_load(1);
        push_frame(1, N_PTS);
        @(posedge clk);
        #1 load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N_PTS; k++) begin
            x_re[k] = vec[2*N_PTS+k].in_re;
            x_im[k] = vec[2*N_PTS+k].in_im;
        end
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_drain("ovr_drain", 30);
        check("ovr_pulses", 64'(ovr_cnt - o0), 64'd1);

        // Back-to-back: load of frame 4 coincides with idx-7 handshake of frame 3
        o0 = ovr_cnt;
        drive_load(3);
        push_frame(3, N_PTS);
        @(posedge clk);
        #1 load = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        for (int k = 0; k < N_PTS; k++) begin
            x_re[k] = vec[4*N_PTS+k].in_re;
            x_im[k] = vec[4*N_PTS+k].in_im;
        end
        load = 1'b1;
        push_frame(4, N_PTS);
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check("b2b_valid", 64'(out_if.out_valid), 64'd1);
        check("b2b_idx",   64'(out_if.out_idx),   64'd0);
        check("b2b_re",    64'(out_if.out_re),    64'(vec[4*N_PTS].exp_re));
        wait_drain("b2b_drain", 30);
        check("b2b_overrun", 64'(ovr_cnt - o0), 64'd0);

        // Reset after idx 3 of frame 5: remaining beats discarded
        drive_load(5);
        push_frame(5, 4);
        @(posedge clk);
        #1 load = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_if.out_valid), 64'd0);
        check("mid_rst_re",    64'(out_if.out_re),    64'd0);
        check("mid_rst_idx",   64'(out_if.out_idx),   64'd0);
        check("mid_rst_busy",  64'(busy),             64'd0);
        check("mid_rst_queue", 64'(exp_q.size()),     64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        drive_load(6);
        push_frame(6, N_PTS);
        @(posedge clk);
        #1 load = 1'b0;
        wait_drain("post_rst_drain", 30);

        // Extreme values (and magnitude corners when enabled)
        drive_load(7);
        push_frame(7, N_PTS);
        @(posedge clk);
        #1 load = 1'b0;
        wait_drain("ext_drain", 30);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fft_out_serializer

`default_nettype wire
